// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcode, state, ALUSel and ImmSel definitions for the RV32I multicycle controller
package rv_ctrl_pkg;

    // Base opcodes recognised by the sequencer
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALUSel codes: {funct7[5], funct3} of the matching R-type operation
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // ImmSel codes
    localparam logic [1:0] IMM_I   = 2'b00;
    localparam logic [1:0] IMM_S   = 2'b01;
    localparam logic [1:0] IMM_B   = 2'b10;
    localparam logic [1:0] IMM_RSV = 2'b11;

    // Sequencer states; IDLE must stay the all-zero encoding
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
`ifdef RV_BRANCH_EN
        ST_HALT,
        ST_BRANCH
`else
        ST_HALT
`endif
    } state_t;

    // Loads and stores take the extra MEM pass through the shared port
    function automatic logic isMemOp(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational opcode/funct3/funct7 to ALUSel, BSel and ImmSel decode
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] aluSel,
    output logic       bSel,
    output logic [1:0] immSel
);

    // Datapath select lines per instruction class; the FSM decides when they are visible
    always_comb begin
        aluSel = ALU_ADD;
        bSel   = 1'b0;
        immSel = IMM_I;
        case (opcode)
            OP_R: begin
                aluSel = {funct7b5, funct3};
            end
            OP_I: begin
                bSel   = 1'b1;
                // Only the shift-right group uses bit 30 as an opcode extension;
                // elsewhere it is just an immediate bit.
                aluSel = (funct3 == 3'b101) ? {funct7b5, funct3} : {1'b0, funct3};
            end
            OP_LOAD: begin
                bSel   = 1'b1;
            end
            OP_STORE: begin
                bSel   = 1'b1;
                immSel = IMM_S;
            end
            OP_BRANCH: begin
                aluSel = ALU_SUB;
                immSel = IMM_B;
            end
            default: begin
                aluSel = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer; RV_BRANCH_EN adds beq/bne
module multicycle_controller
    import rv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instructionCode,
    input  logic        mem_ready,
    input  logic        BrEq,
    output logic        MemReq,
    output logic        AddrSel,
    output logic        MemRW,
    output logic        IRWEn,
    output logic        PCWEn,
    output logic        PCSel,
    output logic [1:0]  ImmSel,
    output logic        BSel,
    output logic [3:0]  ALUSel,
    output logic        RegWEn,
    output logic        WBSel,
    output logic        illegal
);

    state_t state;
    state_t nextState;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       isLoad;
    logic       isStore;
    logic [3:0] decAluSel;
    logic       decBSel;
    logic [1:0] decImmSel;

    assign opcode  = instructionCode[6:0];
    assign funct3  = instructionCode[14:12];
    assign isLoad  = (opcode == OP_LOAD);
    assign isStore = (opcode == OP_STORE);

`ifdef RV_BRANCH_EN
    logic unusedBits;
    assign unusedBits = ^{instructionCode[31], instructionCode[29:15], instructionCode[11:7]};
`else
    logic unusedBits;
    assign unusedBits = ^{BrEq, instructionCode[31], instructionCode[29:15], instructionCode[11:7]};
`endif

    alu_decoder u_alu_decoder (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7b5 (instructionCode[30]),
        .aluSel   (decAluSel),
        .bSel     (decBSel),
        .immSel   (decImmSel)
    );

    // State register; reset aborts any transaction immediately by forcing IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and Moore/Mealy outputs; decoder outputs are only exposed in EXEC, MEM and BRANCH
    always_comb begin
        nextState = state;
        MemReq    = 1'b0;
        AddrSel   = 1'b0;
        MemRW     = 1'b0;
        IRWEn     = 1'b0;
        PCWEn     = 1'b0;
        PCSel     = 1'b0;
        ImmSel    = IMM_I;
        BSel      = 1'b0;
        ALUSel    = ALU_ADD;
        RegWEn    = 1'b0;
        WBSel     = 1'b0;
        illegal   = 1'b0;
        case (state)
            ST_IDLE: begin
                nextState = ST_FETCH;
            end
            ST_FETCH: begin
                MemReq = 1'b1;
                if (mem_ready) begin
                    IRWEn     = 1'b1;
                    PCWEn     = 1'b1;
                    nextState = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE: nextState = ST_EXEC;
`ifdef RV_BRANCH_EN
                    OP_BRANCH: nextState = (funct3[2:1] == 2'b00) ? ST_BRANCH : ST_HALT;
`endif
                    default: nextState = ST_HALT;
                endcase
            end
            ST_EXEC: begin
                ImmSel    = decImmSel;
                BSel      = decBSel;
                ALUSel    = decAluSel;
                nextState = isMemOp(opcode) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                MemReq  = 1'b1;
                AddrSel = 1'b1;
                MemRW   = isStore;
                ImmSel  = decImmSel;
                BSel    = decBSel;
                ALUSel  = decAluSel;
                if (mem_ready) begin
                    nextState = isLoad ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                RegWEn    = 1'b1;
                WBSel     = isLoad;
                nextState = ST_FETCH;
            end
            ST_HALT: begin
                illegal = 1'b1;
            end
`ifdef RV_BRANCH_EN
            ST_BRANCH: begin
                ImmSel = decImmSel;
                ALUSel = decAluSel;
                // funct3[0] distinguishes bne from beq, so it inverts the equality flag
                if (BrEq ^ funct3[0]) begin
                    PCSel = 1'b1;
                    PCWEn = 1'b1;
                end
                nextState = ST_FETCH;
            end
`endif
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller with directed instruction vectors
module tb_multicycle_controller;
    import rv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instructionCode = 32'h0;
    logic        mem_ready = 1'b0;
    logic        BrEq = 1'b0;
    logic        MemReq, AddrSel, MemRW, IRWEn, PCWEn, PCSel, BSel, RegWEn, WBSel, illegal;
    logic [1:0]  ImmSel;
    logic [3:0]  ALUSel;

    multicycle_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instructionCode (instructionCode),
        .mem_ready       (mem_ready),
        .BrEq            (BrEq),
        .MemReq          (MemReq),
        .AddrSel         (AddrSel),
        .MemRW           (MemRW),
        .IRWEn           (IRWEn),
        .PCWEn           (PCWEn),
        .PCSel           (PCSel),
        .ImmSel          (ImmSel),
        .BSel            (BSel),
        .ALUSel          (ALUSel),
        .RegWEn          (RegWEn),
        .WBSel           (WBSel),
        .illegal         (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] vec;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    // Packed output order: MemReq AddrSel MemRW IRWEn PCWEn PCSel ImmSel[1:0] BSel ALUSel[3:0] RegWEn WBSel illegal
    function automatic logic [15:0] mk(input logic mr, input logic as, input logic rw, input logic ir,
                                       input logic pc, input logic ps, input logic [1:0] imm, input logic bs,
                                       input logic [3:0] alu, input logic rg, input logic wb, input logic il);
        return {mr, as, rw, ir, pc, ps, imm, bs, alu, rg, wb, il};
    endfunction

    logic [15:0] dutVec;
    assign dutVec = {MemReq, AddrSel, MemRW, IRWEn, PCWEn, PCSel, ImmSel, BSel, ALUSel, RegWEn, WBSel, illegal};

    // Monitor: pops one expectation per cycle in which one is pending, sampled mid-cycle
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            nChecks++;
            if (dutVec !== e.vec) begin
                nFails++;
                $display("FAIL %s: outputs got %h expected %h (instr %h)", e.tag, dutVec, e.vec, instructionCode);
            end
        end
    end

    localparam logic [15:0] ZV  = 16'h0;
    localparam logic [15:0] F0  = 16'h8000;
    localparam logic [15:0] F1  = 16'h9800;
    localparam logic [15:0] WBA = 16'h0004;
    localparam logic [15:0] WBL = 16'h0006;
    localparam logic [15:0] ILL = 16'h0001;

    task automatic step(input logic rdy, input string tag, input logic [15:0] v);
        exp_t e;
        mem_ready = rdy;
        e.tag = tag;
        e.vec = v;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic doFetch(input logic [31:0] code, input int waits, input logic decodeRdy);
        instructionCode = code;
        for (int i = 0; i < waits; i++) step(1'b0, "fetchWait", F0);
        step(1'b1, "fetchReady", F1);
        step(decodeRdy, "decode", ZV);
    endtask

    task automatic doAlu(input logic [31:0] code, input int waits, input logic [15:0] execVec, input logic strayRdy);
        doFetch(code, waits, strayRdy);
        step(strayRdy, "aluExec", execVec);
        step(strayRdy, "aluWb", WBA);
    endtask

    task automatic doStore(input logic [31:0] code, input int memWaits);
        logic [15:0] xv;
        logic [15:0] mv;
        xv = mk(0, 0, 0, 0, 0, 0, IMM_S, 1, ALU_ADD, 0, 0, 0);
        mv = mk(1, 1, 1, 0, 0, 0, IMM_S, 1, ALU_ADD, 0, 0, 0);
        doFetch(code, 0, 1'b0);
        step(1'b0, "storeExec", xv);
        for (int i = 0; i < memWaits; i++) step(1'b0, "storeMemWait", mv);
        step(1'b1, "storeMem", mv);
    endtask

    task automatic doLoad(input logic [31:0] code, input int memWaits);
        logic [15:0] xv;
        logic [15:0] mv;
        xv = mk(0, 0, 0, 0, 0, 0, IMM_I, 1, ALU_ADD, 0, 0, 0);
        mv = mk(1, 1, 0, 0, 0, 0, IMM_I, 1, ALU_ADD, 0, 0, 0);
        doFetch(code, 0, 1'b0);
        step(1'b0, "loadExec", xv);
        for (int i = 0; i < memWaits; i++) step(1'b0, "loadMemWait", mv);
        step(1'b1, "loadMem", mv);
        step(1'b0, "loadWb", WBL);
    endtask

    task automatic resetCycle();
        rst_n = 1'b0;
        step(1'b0, "resetHeld", ZV);
        rst_n = 1'b1;
        step(1'b0, "idle", ZV);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        resetCycle();

        // addi x1,x0,3: mem_ready strays high outside requests and must be ignored
        doAlu(32'h00300093, 0, mk(0, 0, 0, 0, 0, 0, IMM_I, 1, ALU_ADD, 0, 0, 0), 1'b1);
        // add x3,x1,x2 with two fetch wait cycles
        doAlu(32'h002081B3, 2, ZV, 1'b0);
        // sub x1,x2,x3
        doAlu(32'h403100B3, 0, mk(0, 0, 0, 0, 0, 0, IMM_I, 0, ALU_SUB, 0, 0, 0), 1'b0);
        // srai x5,x6,2 keeps bit 30
        doAlu(32'h40235293, 0, mk(0, 0, 0, 0, 0, 0, IMM_I, 1, ALU_SRA, 0, 0, 0), 1'b0);
        // addi x1,x0,-1 has bit 30 set but is still an add
        doAlu(32'hFFF00093, 0, mk(0, 0, 0, 0, 0, 0, IMM_I, 1, ALU_ADD, 0, 0, 0), 1'b0);
        // andi x1,x1,7
        doAlu(32'h0070F093, 1, mk(0, 0, 0, 0, 0, 0, IMM_I, 1, ALU_AND, 0, 0, 0), 1'b0);
        // sw x14,8(x2) zero-wait then with one wait
        doStore(32'h00E12423, 0);
        doStore(32'h00E12423, 1);
        // lw x15,8(x2) with three MEM wait cycles
        doLoad(32'h00812783, 3);
        doLoad(32'h00812783, 0);

        // lw again, reset asserted asynchronously while waiting in MEM
        doFetch(32'h00812783, 0, 1'b0);
        step(1'b0, "loadExec", mk(0, 0, 0, 0, 0, 0, IMM_I, 1, ALU_ADD, 0, 0, 0));
        step(1'b0, "loadMemWait", mk(1, 1, 0, 0, 0, 0, IMM_I, 1, ALU_ADD, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (MemReq !== 1'b0) begin
            nFails++;
            $display("FAIL asyncResetMemReq: MemReq got %b expected 0", MemReq);
        end
        step(1'b0, "resetDuringMem", ZV);
        rst_n = 1'b1;
        step(1'b0, "idleAfterAbort", ZV);

        // Unsupported opcode: HALT is sticky and ignores mem_ready
        doFetch(32'h0000007F, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(i[0], "halt", ILL);

        // beq x0,x0,0 with BrEq=1
        resetCycle();
        BrEq = 1'b1;
        doFetch(32'h00000063, 0, 1'b0);
`ifdef RV_BRANCH_EN
        step(1'b0, "branchTaken", mk(0, 0, 0, 0, 1, 1, IMM_B, 0, ALU_SUB, 0, 0, 0));
        step(1'b1, "fetchAfterBranch", F1);
`else
        for (int i = 0; i < 3; i++) step(1'b1, "branchHalt", ILL);
`endif

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("FAIL drain: pending expectations got %0d expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
